// File: rtl/code_check_sm.sv
// code_check_sm: checks entered codes against a stored code, manages unlock window, failure count and lockout.
module code_check_sm #(
  parameter logic [15:0] CODE_DEFAULT   = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          UNLOCK_CYCLES  = 8,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] code_in,
  input  logic        ena,
  input  logic        timeout,
  input  logic        prog,
  output logic        unlocked,
  output logic        fail,
  output logic        locked_out,
  output logic [3:0]  tries_left
);
  localparam int TMAX = UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_UNLOCK = 2'd1, S_FAIL = 2'd2, S_LOCK = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    tries_q, tries_d;
  logic [15:0]   code_q, code_d;
  logic          ena_q, chk, hit;
  assign chk = ena & ~ena_q;
  assign hit = ~timeout & (code_in == code_q);
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tries_d = tries_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: if (chk) begin
        state_d = hit ? S_UNLOCK : S_FAIL;
        timer_d = '0;
        tries_d = hit ? 4'(MAX_TRIES) : (tries_q != 4'd0 ? tries_q - 4'd1 : 4'd0);
      end
      S_FAIL: begin
        state_d = tries_q == 4'd0 ? S_LOCK : S_IDLE;
        timer_d = '0;
      end
      // a program request in the final cycle still restarts the window
      S_UNLOCK: if (chk & prog) begin
        code_d  = code_in;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
        state_d = timer_q == TW'(UNLOCK_CYCLES - 1) ? S_IDLE : S_UNLOCK;
      end
      default: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          tries_d = 4'(MAX_TRIES);
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      tries_q <= 4'(MAX_TRIES);
      code_q  <= CODE_DEFAULT;
      ena_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
      code_q  <= code_d;
      ena_q   <= ena;
    end
  end
  assign unlocked   = state_q == S_UNLOCK;
  assign fail       = state_q == S_FAIL;
  assign locked_out = state_q == S_LOCK;
  assign tries_left = tries_q;
endmodule

// File: tb/tb_code_check_sm.sv
// tb_code_check_sm: directed tests for code_check_sm with hand-computed expectations.
module tb_code_check_sm;
  logic        clk = 1'b0;
  logic        rst, ena, timeout, prog;
  logic [15:0] code_in;
  logic        unlocked, fail, locked_out;
  logic [3:0]  tries_left;
  int total = 0, bad = 0;
  code_check_sm dut (
    .clk(clk), .rst(rst), .code_in(code_in), .ena(ena), .timeout(timeout), .prog(prog),
    .unlocked(unlocked), .fail(fail), .locked_out(locked_out), .tries_left(tries_left)
  );
  always #5 clk = ~clk;
  // called at a negedge; returns at the negedge just after the sampling posedge
  task automatic pulse(input logic [15:0] c, input logic t, input logic p);
    code_in = c; timeout = t; prog = p; ena = 1'b1;
    @(negedge clk);
    ena = 1'b0; timeout = 1'b0; prog = 1'b0;
  endtask
  task automatic do_reset(input logic e);
    rst = 1'b1; ena = e;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    code_in = 16'h1234; timeout = 1'b0; prog = 1'b0;
    do_reset(1'b1);
    @(negedge clk);
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL reset_unlocked got=%b exp=0", unlocked); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b exp=0", fail); end
    total++; if (locked_out !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked_out); end
    total++; if (tries_left !== 4'd3) begin bad++; $display("FAIL reset_tries got=%0d exp=3", tries_left); end
    ena = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_unlock;
    int n = 0;
    pulse(16'h1234, 1'b0, 1'b0);
    while (unlocked && n < 40) begin n++; @(negedge clk); end
    total++; if (n !== 8) begin bad++; $display("FAIL unlock_len got=%0d exp=8", n); end
    total++; if (tries_left !== 4'd3) begin bad++; $display("FAIL unlock_tries got=%0d exp=3", tries_left); end
  endtask
  task automatic test_lockout;
    int n = 0;
    logic saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse(16'h0000, 1'b0, 1'b0);
      total++; if (fail !== 1'b1) begin bad++; $display("FAIL lo_fail%0d got=%b exp=1", i, fail); end
      total++; if (tries_left !== 4'(2 - i)) begin bad++; $display("FAIL lo_tries%0d got=%0d exp=%0d", i, tries_left, 2 - i); end
      @(negedge clk);
      total++; if (fail !== 1'b0) begin bad++; $display("FAIL lo_failw%0d got=%b exp=0", i, fail); end
    end
    while (locked_out && n < 40) begin
      code_in = 16'h1234; ena = (n == 3);
      if (unlocked) saw = 1'b1;
      n++;
      @(negedge clk);
    end
    ena = 1'b0;
    total++; if (n !== 16) begin bad++; $display("FAIL lo_len got=%0d exp=16", n); end
    total++; if (saw !== 1'b0 || unlocked !== 1'b0) begin bad++; $display("FAIL lo_ignored got=%b exp=0", saw | unlocked); end
    total++; if (tries_left !== 4'd3) begin bad++; $display("FAIL lo_tries_after got=%0d exp=3", tries_left); end
  endtask
  task automatic test_timeout;
    pulse(16'h1234, 1'b1, 1'b0);
    total++; if (fail !== 1'b1 || unlocked !== 1'b0) begin bad++; $display("FAIL to_fail got=%b%b exp=10", fail, unlocked); end
    total++; if (tries_left !== 4'd2) begin bad++; $display("FAIL to_tries got=%0d exp=2", tries_left); end
    @(negedge clk);
  endtask
  task automatic test_program;
    int n = 0;
    pulse(16'h1234, 1'b0, 1'b0);
    total++; if (unlocked !== 1'b1 || tries_left !== 4'd3) begin bad++; $display("FAIL pg_unlock got=%b/%0d exp=1/3", unlocked, tries_left); end
    repeat (3) @(negedge clk);
    pulse(16'hBEEF, 1'b0, 1'b1);
    while (unlocked && n < 40) begin n++; @(negedge clk); end
    total++; if (n !== 8) begin bad++; $display("FAIL pg_restart got=%0d exp=8", n); end
    pulse(16'h1234, 1'b0, 1'b0);
    total++; if (fail !== 1'b1 || tries_left !== 4'd2) begin bad++; $display("FAIL pg_old_fails got=%b/%0d exp=1/2", fail, tries_left); end
    @(negedge clk);
    pulse(16'hBEEF, 1'b0, 1'b0);
    total++; if (unlocked !== 1'b1 || tries_left !== 4'd3) begin bad++; $display("FAIL pg_new_unlocks got=%b/%0d exp=1/3", unlocked, tries_left); end
    // program again exactly in the final window cycle
    repeat (7) @(negedge clk);
    pulse(16'hBEEF, 1'b0, 1'b1);
    n = 0;
    while (unlocked && n < 40) begin n++; @(negedge clk); end
    total++; if (n !== 8) begin bad++; $display("FAIL pg_last_cycle got=%0d exp=8", n); end
    do_reset(1'b0);
    pulse(16'hBEEF, 1'b0, 1'b0);
    total++; if (fail !== 1'b1) begin bad++; $display("FAIL pg_rst_beef got=%b exp=1", fail); end
    @(negedge clk);
    pulse(16'h1234, 1'b0, 1'b0);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL pg_rst_default got=%b exp=1", unlocked); end
    n = 0;
    while (unlocked && n < 40) begin n++; @(negedge clk); end
  endtask
  task automatic test_back_to_back;
    int n = 0;
    for (int i = 0; i < 2; i++) begin pulse(16'hAAAA, 1'b0, 1'b0); @(negedge clk); end
    total++; if (tries_left !== 4'd1) begin bad++; $display("FAIL bb_tries got=%0d exp=1", tries_left); end
    pulse(16'h1234, 1'b0, 1'b0);
    total++; if (unlocked !== 1'b1 || tries_left !== 4'd3) begin bad++; $display("FAIL bb_unlock got=%b/%0d exp=1/3", unlocked, tries_left); end
    while (unlocked && n < 40) begin n++; @(negedge clk); end
    for (int i = 0; i < 2; i++) begin pulse(16'h5555, 1'b0, 1'b0); @(negedge clk); end
    total++; if (locked_out !== 1'b0 || tries_left !== 4'd1) begin bad++; $display("FAIL bb_no_lock got=%b/%0d exp=0/1", locked_out, tries_left); end
  endtask
  initial begin
    rst = 1'b1; ena = 1'b1; timeout = 1'b0; prog = 1'b0; code_in = 16'h0;
    @(negedge clk);
    test_reset;
    test_unlock;
    test_lockout;
    test_timeout;
    test_program;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
